// File: rtl/wb_select_stage.sv
// Writeback-stage register and result selector for the 16-bit core, with retire counter.
// Optional WB_ERR_EN: flags OutSel=7 as illegal and suppresses its write.
module wb_select_stage #(
  parameter int DW   = 16,
  parameter int RW   = 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [2:0]      OutSel,
  input  logic            mem_to_reg,
  input  logic            reg_write,
  input  logic [RW-1:0]   wr_reg_in,
  input  logic [DW-1:0]   alu_out,
  input  logic [DW-1:0]   mem_data,
  input  logic [DW-1:0]   pc_plus2,
  input  logic [DW-1:0]   rs_data,
  input  logic [DW-1:0]   imm,
  input  logic            halt_in,
  output logic [DW-1:0]   wr_data,
  output logic [RW-1:0]   wr_reg,
  output logic            wr_en,
  output logic            out_valid,
  output logic            halt,
  output logic [CNTW-1:0] retire_cnt,
  output logic            err
);

  logic [DW-1:0]   w_btr;
  logic [DW-1:0]   w_sel;
  logic [DW-1:0]   w_data_ld;
  logic            w_en_ld;
  logic [DW-1:0]   r_wr_data;
  logic [RW-1:0]   r_wr_reg;
  logic            r_wr_en;
  logic            r_out_valid;
  logic            r_halt;
  logic [CNTW-1:0] r_retire_cnt;

  always_comb begin
    w_btr = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      w_btr[i] = rs_data[DW-1-i];
    end
  end

  always_comb begin
    w_sel = '0;
    case (OutSel)
      3'd0:    w_sel = w_btr;
      3'd1:    w_sel = {{(DW-1){1'b0}}, 1'b1};
      3'd2:    w_sel = '0;
      3'd3:    w_sel = pc_plus2;
      3'd4:    w_sel = imm;
      3'd5:    w_sel = {rs_data[7:0], imm[7:0]};
      default: w_sel = mem_to_reg ? mem_data : alu_out;
    endcase
  end

`ifdef WB_ERR_EN
  logic w_illegal;
  logic r_err;

  assign w_illegal = (OutSel == 3'd7);
  assign w_data_ld = w_illegal ? '0 : w_sel;
  assign w_en_ld   = in_valid & reg_write & ~halt_in & ~w_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (!flush && !stall && in_valid && w_illegal) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_data_ld = w_sel;
  assign w_en_ld   = in_valid & reg_write & ~halt_in;
  assign err       = 1'b0;
`endif

  // A flush still captures the selected data/address so the bubble contents are deterministic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_data    <= '0;
      r_wr_reg     <= '0;
      r_wr_en      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_halt       <= 1'b0;
      r_retire_cnt <= '0;
    end else if (flush) begin
      r_wr_data    <= w_data_ld;
      r_wr_reg     <= wr_reg_in;
      r_wr_en      <= 1'b0;
      r_out_valid  <= 1'b0;
    end else if (!stall) begin
      r_wr_data    <= w_data_ld;
      r_wr_reg     <= wr_reg_in;
      r_wr_en      <= w_en_ld;
      r_out_valid  <= in_valid;
      if (in_valid) begin
        r_retire_cnt <= r_retire_cnt + 1'b1;
        if (halt_in) begin
          r_halt <= 1'b1;
        end
      end
    end
  end

  assign wr_data    = r_wr_data;
  assign wr_reg     = r_wr_reg;
  assign wr_en      = r_wr_en;
  assign out_valid  = r_out_valid;
  assign halt       = r_halt;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed self-checking bench for wb_select_stage; expectations follow WB_ERR_EN when defined.
module tb_wb_select_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, mem_to_reg, reg_write, halt_in;
  logic [2:0]  OutSel;
  logic [2:0]  wr_reg_in;
  logic [15:0] alu_out, mem_data, pc_plus2, rs_data, imm;
  logic [15:0] wr_data;
  logic [2:0]  wr_reg;
  logic        wr_en, out_valid, halt, err;
  logic [15:0] retire_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  wb_select_stage #(.DW(16), .RW(3), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .OutSel(OutSel), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .wr_reg_in(wr_reg_in), .alu_out(alu_out), .mem_data(mem_data),
    .pc_plus2(pc_plus2), .rs_data(rs_data), .imm(imm), .halt_in(halt_in),
    .wr_data(wr_data), .wr_reg(wr_reg), .wr_en(wr_en), .out_valid(out_valid),
    .halt(halt), .retire_cnt(retire_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'($urandom); flush = 1'($urandom); in_valid = 1'($urandom);
    OutSel = 3'($urandom); mem_to_reg = 1'($urandom); reg_write = 1'($urandom);
    wr_reg_in = 3'($urandom); alu_out = 16'($urandom); mem_data = 16'($urandom);
    pc_plus2 = 16'($urandom); rs_data = 16'($urandom); imm = 16'($urandom);
    halt_in = 1'($urandom);
    step();
    step();
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_reg", wr_reg, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halt", halt, 0);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_err", err, 0);

    rst = 0; stall = 0; flush = 0; in_valid = 1; reg_write = 1; halt_in = 0;
    mem_to_reg = 0; OutSel = 0; rs_data = 16'h8001; wr_reg_in = 3'd5;
    step();
    chk("btr_8001", wr_data, 16'h8001);
    chk("btr_wr_reg", wr_reg, 5);
    chk("btr_wr_en", wr_en, 1);
    chk("btr_out_valid", out_valid, 1);
    chk("btr_retire", retire_cnt, 1);
    rs_data = 16'h1234;
    step();
    chk("btr_1234", wr_data, 16'h2C48);
    OutSel = 5; rs_data = 16'h00AB; imm = 16'hFFCD; wr_reg_in = 3'd3;
    step();
    chk("slbi", wr_data, 16'hABCD);
    chk("slbi_wr_reg", wr_reg, 3);
    OutSel = 3; pc_plus2 = 16'h0102;
    step();
    chk("link", wr_data, 16'h0102);
    OutSel = 1;
    step();
    chk("set_true", wr_data, 16'h0001);
    OutSel = 2;
    step();
    chk("set_false", wr_data, 16'h0000);
    OutSel = 4; imm = 16'hFFCD;
    step();
    chk("lbi", wr_data, 16'hFFCD);
    OutSel = 6; mem_to_reg = 0; alu_out = 16'h1357;
    step();
    chk("alu_sel", wr_data, 16'h1357);
    chk("retire_8", retire_cnt, 8);

    rst = 1;
    step();
    rst = 0; OutSel = 6; mem_to_reg = 1; mem_data = 16'h5A5A; wr_reg_in = 3'd6;
    step();
    chk("mem_sel", wr_data, 16'h5A5A);
    chk("mem_retire", retire_cnt, 1);
    stall = 1; OutSel = 1; mem_data = 16'h0000; wr_reg_in = 3'd2; reg_write = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_wr_data", wr_data, 16'h5A5A);
      chk("stall_wr_reg", wr_reg, 6);
      chk("stall_wr_en", wr_en, 1);
      chk("stall_retire", retire_cnt, 1);
    end
    flush = 1;
    step();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_wr_en", wr_en, 0);
    chk("flush_wr_data", wr_data, 16'h0001);
    chk("flush_retire", retire_cnt, 1);
    stall = 0; flush = 0; in_valid = 0; reg_write = 1;
    step();
    chk("bubble_out_valid", out_valid, 0);
    chk("bubble_wr_en", wr_en, 0);
    chk("bubble_retire", retire_cnt, 1);

    in_valid = 1; OutSel = 7; mem_to_reg = 0; alu_out = 16'hBEEF;
    step();
`ifdef WB_ERR_EN
    chk("sel7_wr_data", wr_data, 16'h0000);
    chk("sel7_wr_en", wr_en, 0);
    chk("sel7_err", err, 1);
`else
    chk("sel7_wr_data", wr_data, 16'hBEEF);
    chk("sel7_wr_en", wr_en, 1);
    chk("sel7_err", err, 0);
`endif
    chk("sel7_retire", retire_cnt, 2);

    OutSel = 6; halt_in = 1; reg_write = 1;
    step();
    chk("halt_wr_en", wr_en, 0);
    chk("halt_set", halt, 1);
    chk("halt_retire", retire_cnt, 3);
    halt_in = 0;
    for (int i = 0; i < 5; i++) begin
      alu_out = 16'(i * 16'h0101);
      step();
      chk("halt_sticky", halt, 1);
      chk("post_halt_wr_en", wr_en, 1);
      chk("post_halt_data", wr_data, 16'(i * 16'h0101));
`ifdef WB_ERR_EN
      chk("err_sticky", err, 1);
`endif
    end
    chk("post_halt_retire", retire_cnt, 8);

    rst = 1; stall = 1;
    step();
    chk("rst_stall_out_valid", out_valid, 0);
    chk("rst_stall_halt", halt, 0);
    chk("rst_stall_err", err, 0);
    chk("rst_stall_retire", retire_cnt, 0);
    rst = 0; stall = 0; in_valid = 1;
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk);
    end
    #1;
    chk("retire_ffff", retire_cnt, 16'hFFFF);
    step();
    chk("retire_wrap", retire_cnt, 16'h0000);
    in_valid = 0;
    step();
    chk("retire_idle", retire_cnt, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Writeback-stage pipeline register and result selector of the 16-bit pipelined core.
- Consumes the 3-bit OutSel code produced by the execute-side output control plus all candidate operands.
- Registers the values for one cycle and drives register-file write data, write address and write enable.
- Also keeps a retired-instruction counter for the debug port.

Parameters:
- DW, 16, datapath width (only 16 is supported; BTR and SLBI are defined for 16).
- RW, 3, register address width.
- CNTW, 16, retire counter width.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- stall  in  1  hold stage contents this cycle
- flush  in  1  load a bubble into the stage this cycle
- in_valid  in  1  incoming instruction is real (not a bubble)
- OutSel  in  3  result source code from output control
- mem_to_reg  in  1  for OutSel=6: 1 selects mem_data, 0 selects alu_out
- reg_write  in  1  instruction writes the register file
- wr_reg_in  in  RW  destination register
- alu_out  in  DW  ALU result
- mem_data  in  DW  load data
- pc_plus2  in  DW  link address
- rs_data  in  DW  Rs operand
- imm  in  DW  sign-extended immediate
- halt_in  in  1  instruction is HALT
- wr_data  out  DW  register-file write data
- wr_reg  out  RW  register-file write address
- wr_en  out  1  register-file write strobe
- out_valid  out  1  stage holds a real instruction
- halt  out  1  registered HALT retired (sticky)
- retire_cnt  out  CNTW  count of retired valid instructions
- err  out  1  illegal OutSel flag (only with WB_ERR_EN; tied 0 otherwise)

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high and has the highest priority.
- Register update priority per edge: rst > flush > stall > load.
- rst:
  - out_valid=0, wr_en=0, wr_data=0, wr_reg=0.
  - halt=0, retire_cnt=0, err=0.
- flush (rst=0):
  - out_valid=0, wr_en=0.
  - wr_data and wr_reg take the selected value (don't-care, but deterministic).
  - retire_cnt not incremented.
  - halt unchanged.
- stall (rst=0, flush=0):
  - All outputs hold.
  - retire_cnt holds.
  - wr_en stays at its held value; the register file sees a repeated identical write, which is harmless.
- load: outputs register the combinational selection of the current inputs. Latency is exactly 1 cycle from input to outputs.
- Selection by OutSel:
  - 0 BTR: wr_data[i] = rs_data[15-i] for i = 0..15.
  - 1 set-true: 16'h0001.
  - 2 set-false: 16'h0000.
  - 3 link: pc_plus2.
  - 4 LBI: imm.
  - 5 SLBI: {rs_data[7:0], imm[7:0]}.
  - 6 normal: mem_to_reg ? mem_data : alu_out.
  - 7 illegal: handled as 6 unless WB_ERR_EN.
- Outputs on load:
  - wr_en = in_valid & reg_write & ~halt_in.
  - out_valid = in_valid.
- retire_cnt increments by 1 on each load edge where in_valid=1.
  - Wraps modulo 2^CNTW (FFFF -> 0000).
- halt:
  - Set on a load edge with in_valid=1 and halt_in=1.
  - Once set, it stays set until rst.
  - Further loads continue normally; halt does not stall the stage itself.
- Simultaneous flush and stall: flush wins, and the bubble is inserted.
- rst asserted while stall is asserted: reset values apply on that edge.

Optional Feature:
- Macro: WB_ERR_EN.
- Defined:
  - A load with in_valid=1 and OutSel=7 forces wr_en=0 and wr_data=0.
  - err is set sticky until rst.
  - The instruction still counts as retired.
- Not defined: OutSel=7 is treated as OutSel=6, and err is constant 0.

Test Plan:
- rst=1 for 2 cycles with random inputs -> every output reads 0 on the cycle after the second edge.
- in_valid=1, reg_write=1, OutSel=0, rs_data=16'h8001, wr_reg_in=5 -> next cycle wr_data=16'h8001, wr_reg=5, wr_en=1; then rs_data=16'h1234 -> wr_data=16'h2C48.
- OutSel=5, rs_data=16'h00AB, imm=16'hFFCD -> wr_data=16'hABCD. OutSel=3, pc_plus2=16'h0102 -> wr_data=16'h0102. OutSel=1 -> 16'h0001. OutSel=2 -> 16'h0000.
- Load OutSel=6, mem_to_reg=1, mem_data=16'h5A5A, then stall=1 for 3 cycles with changed inputs -> wr_data stays 16'h5A5A and retire_cnt stays at 1. Assert stall=1 and flush=1 together -> out_valid=0, wr_en=0.
- Preload retire_cnt to FFFF via 65535 valid loads, then one more valid load -> retire_cnt=0000. in_valid=0 loads do not increment.
- halt_in=1 with reg_write=1 -> wr_en=0 and halt=1, and halt stays 1 over 5 further loads. With WB_ERR_EN, OutSel=7 and in_valid=1 -> wr_en=0 and err=1 until rst.
